ocr_frame_controller: RTL and testbench
=======================================

# ocr_frame_controller

Top-level sequencer between the byte-stream receiver and the OCR datapath. Parses a start command from the incoming byte stream, loads exactly one frame of packed image bytes into the image buffer through its write-request interface, launches BNN inference once the buffer reports full, and returns a one-byte result (or error code) on a valid/ready transmit channel. It owns all timeouts so that a stalled host or a hung inference never locks the design.

## Interface
Parameters:
- IMG_BYTES, 113, frame length in bytes; the last byte carries 4 valid bits.
- CMD_START, 8'hA5, byte that opens a frame while idle.
- RX_TIMEOUT, 100000, max idle cycles between frame bytes in LOAD.
- INFER_TIMEOUT, 50000, max cycles from infer_start to infer_done.
- ERR_RX, 8'hFE, result byte on receive timeout.
- ERR_INFER, 8'hFF, result byte on inference timeout.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  controller accepts byte this cycle.
- buf_clear  out  1  one-cycle clear pulse to image buffer.
- buf_data  out  8  byte to image buffer.
- buf_write_request  out  1  write strobe to image buffer.
- buf_write_ready  in  1  buffer can take a byte.
- buf_full  in  1  buffer holds a full frame.
- infer_start  out  1  one-cycle inference launch pulse.
- infer_done  in  1  inference result valid (pulse or level).
- infer_result  in  4  recognised class 0–9.
- tx_data  out  8  result byte.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, LOAD, DRAIN, INFER, WAIT_RESULT, SEND.
- IDLE: rx_ready=1. Accepted byte == CMD_START → buf_clear pulse, byte_cnt=0, rx_timer=0, → LOAD. Any other byte consumed and discarded.
- LOAD: rx_ready = buf_write_ready && byte_cnt < IMG_BYTES. On accept: register rx_data into buf_data, assert buf_write_request next cycle for exactly one cycle, byte_cnt++, rx_timer=0. Otherwise rx_timer++. rx_timer == RX_TIMEOUT → tx_data=ERR_RX, → SEND. Accept of byte IMG_BYTES → DRAIN.
- DRAIN: wait for buf_full=1 → INFER. No timeout needed (buffer full follows last write by ≤2 cycles).
- INFER: infer_start=1 for one cycle, inf_timer=0, → WAIT_RESULT.
- WAIT_RESULT: infer_done=1 → tx_data={4'h0, infer_result}, → SEND. inf_timer == INFER_TIMEOUT → tx_data=ERR_INFER, → SEND. infer_done wins if both occur on the same cycle.
- SEND: tx_valid=1, tx_data stable until tx_valid && tx_ready → IDLE (no buffer clear; image stays until next CMD_START).
- Bytes are never accepted outside IDLE/LOAD (rx_ready=0); CMD_START inside LOAD is image data.
- byte_cnt 7 bits; rx_timer and inf_timer sized by $clog2 of their parameters +1; timers saturate, never wrap.

## Timing
- Reset (rst high at a clk edge): state IDLE; rx_ready=1 on the following cycle; buf_clear, buf_write_request, infer_start, tx_valid, busy = 0; buf_data, tx_data = 8'h00; counters 0. Reset mid-frame abandons the frame; no pulse is emitted.
- CMD_START accepted at cycle N → buf_clear and busy high at N+1; first image byte acceptable at N+1.
- Image byte accepted at cycle N → buf_write_request=1 with buf_data at N+1; back-to-back accepts give back-to-back writes.
- buf_full seen at cycle N in DRAIN → infer_start at N+1.
- infer_done at N → tx_valid at N+1.
- Handshake on tx at N → tx_valid=0, busy=0, rx_ready=1 at N+1.
- Minimum frame turnaround: 1 + IMG_BYTES + DRAIN + 1 + inference latency + 1 + tx stall cycles.

## Test plan
- Reset, then feed 8'h00, 8'h13 in IDLE → both consumed, buf_clear never pulses, busy stays 0.
- 8'hA5 then 113 back-to-back bytes, buffer model full after byte 113, infer_done with result 4'd7 after 20 cycles → exactly 113 write pulses, one infer_start, tx_data=8'h07 held until tx_ready.
- Same frame with buf_write_ready dropped for 5 cycles mid-frame → rx_ready low those cycles, no lost or duplicated write, 113 writes total.
- 8'hA5 then 40 bytes, then silence for RX_TIMEOUT cycles → tx_data=8'hFE, no infer_start, return to IDLE after handshake.
- Full frame, infer_done never asserted → tx_data=8'hFF exactly INFER_TIMEOUT cycles after infer_start; infer_done on the timeout cycle → class result sent instead.
- rst asserted at byte 60 → all outputs at reset values next cycle; subsequent full frame completes normally with correct result.

Source files
------------

// File: rtl/ocr_frame_controller_if.sv
// Byte-stream, image-buffer, inference and result channels of the OCR frame controller.
// master = controller side, slave = surrounding receiver/buffer/BNN/transmitter.
interface ocr_frame_controller_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       buf_clear;
   logic [7:0] buf_data;
   logic       buf_write_request;
   logic       buf_write_ready;
   logic       buf_full;
   logic       infer_start;
   logic       infer_done;
   logic [3:0] infer_result;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;

   modport master (
      input  rx_data, rx_valid, buf_write_ready, buf_full, infer_done, infer_result, tx_ready,
      output rx_ready, buf_clear, buf_data, buf_write_request, infer_start, tx_data, tx_valid, busy
   );

   modport slave (
      output rx_data, rx_valid, buf_write_ready, buf_full, infer_done, infer_result, tx_ready,
      input  rx_ready, buf_clear, buf_data, buf_write_request, infer_start, tx_data, tx_valid, busy
   );
endinterface

// File: rtl/ocr_frame_controller.sv
// Frame sequencer: CMD_START opens a frame, IMG_BYTES go to the image buffer (one write per accept,
// one cycle later), inference launches on buf_full, one result/error byte is held on tx until taken.
module ocr_frame_controller #(
   parameter int         IMG_BYTES     = 113,
   parameter logic [7:0] CMD_START     = 8'hA5,
   parameter int         RX_TIMEOUT    = 100000,
   parameter int         INFER_TIMEOUT = 50000,
   parameter logic [7:0] ERR_RX        = 8'hFE,
   parameter logic [7:0] ERR_INFER     = 8'hFF
) (
   input  logic                   clk,
   input  logic                   rst,
   ocr_frame_controller_if.master bus
);
   localparam int RXT_W = $clog2(RX_TIMEOUT) + 1;
   localparam int INT_W = $clog2(INFER_TIMEOUT) + 1;

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, INFER, WAIT_RESULT, SEND} state_t;

   state_t           state_q, state_d;
   logic [6:0]       byte_cnt_q, byte_cnt_d;
   logic [RXT_W-1:0] rx_timer_q, rx_timer_d;
   logic [INT_W-1:0] inf_timer_q, inf_timer_d;
   logic [7:0]       buf_data_q, buf_data_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             buf_clear_q, buf_clear_d;
   logic             buf_wr_q, buf_wr_d;
   logic             infer_start_q, infer_start_d;
   logic             tx_valid_q, tx_valid_d;
   logic             rx_ready;
   logic             rx_accept;

   assign rx_ready  = (state_q == IDLE) ||
                      (state_q == LOAD && bus.buf_write_ready && byte_cnt_q < 7'(IMG_BYTES));
   assign rx_accept = rx_ready && bus.rx_valid;

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      rx_timer_d    = rx_timer_q;
      inf_timer_d   = inf_timer_q;
      buf_data_d    = buf_data_q;
      tx_data_d     = tx_data_q;
      buf_clear_d   = 1'b0;
      buf_wr_d      = 1'b0;
      infer_start_d = 1'b0;
      tx_valid_d    = tx_valid_q;
      unique case (state_q)
         IDLE: begin
            if (rx_accept && bus.rx_data == CMD_START) begin
               buf_clear_d = 1'b1;
               byte_cnt_d  = '0;
               rx_timer_d  = '0;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            if (rx_accept) begin
               buf_data_d = bus.rx_data;
               buf_wr_d   = 1'b1;
               byte_cnt_d = byte_cnt_q + 7'd1;
               rx_timer_d = '0;
               if (byte_cnt_q == 7'(IMG_BYTES - 1)) state_d = DRAIN;
            end else if (rx_timer_q == RXT_W'(RX_TIMEOUT)) begin
               tx_data_d  = ERR_RX;
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end else begin
               rx_timer_d = rx_timer_q + 1'b1;
            end
         end
         DRAIN: begin
            if (bus.buf_full) begin
               infer_start_d = 1'b1;
               inf_timer_d   = '0;
               state_d       = INFER;
            end
         end
         INFER: begin
            inf_timer_d = inf_timer_q + 1'b1;
            state_d     = WAIT_RESULT;
         end
         WAIT_RESULT: begin
            // Timer counts cycles since the launch pulse; the error byte lands INFER_TIMEOUT cycles after it.
            if (bus.infer_done) begin
               tx_data_d  = {4'h0, bus.infer_result};
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end else if (inf_timer_q >= INT_W'(INFER_TIMEOUT - 1)) begin
               tx_data_d  = ERR_INFER;
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end else begin
               inf_timer_d = inf_timer_q + 1'b1;
            end
         end
         SEND: begin
            if (tx_valid_q && bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         byte_cnt_q    <= '0;
         rx_timer_q    <= '0;
         inf_timer_q   <= '0;
         buf_data_q    <= 8'h00;
         tx_data_q     <= 8'h00;
         buf_clear_q   <= 1'b0;
         buf_wr_q      <= 1'b0;
         infer_start_q <= 1'b0;
         tx_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         rx_timer_q    <= rx_timer_d;
         inf_timer_q   <= inf_timer_d;
         buf_data_q    <= buf_data_d;
         tx_data_q     <= tx_data_d;
         buf_clear_q   <= buf_clear_d;
         buf_wr_q      <= buf_wr_d;
         infer_start_q <= infer_start_d;
         tx_valid_q    <= tx_valid_d;
      end
   end

   assign bus.rx_ready          = rx_ready;
   assign bus.buf_clear         = buf_clear_q;
   assign bus.buf_data          = buf_data_q;
   assign bus.buf_write_request = buf_wr_q;
   assign bus.infer_start       = infer_start_q;
   assign bus.tx_data           = tx_data_q;
   assign bus.tx_valid          = tx_valid_q;
   assign bus.busy              = (state_q != IDLE);
endmodule

// File: tb/tb_ocr_frame_controller.sv
// Bench for ocr_frame_controller: table vectors, directed corner frames and randomized frames
// checked against a frame-level model of the expected result byte, timing and write counts.
module tb_ocr_frame_controller;
   localparam int IMG = 113;
   localparam int RXT = 300;
   localparam int INT = 60;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ocr_frame_controller_if bus();

   ocr_frame_controller #(.IMG_BYTES(IMG), .RX_TIMEOUT(RXT), .INFER_TIMEOUT(INT)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Environment model: image buffer and BNN engine, observed mid-cycle.
   int         wcnt = 0, n_wr = 0, n_clear = 0, n_start = 0;
   int         start_cyc = -1000000;
   int         infer_lat = -1;
   logic [7:0] mem [IMG];

   always @(negedge clk) begin
      if (bus.buf_clear === 1'b1) begin
         wcnt = 0;
         n_clear++;
      end else if (bus.buf_write_request === 1'b1) begin
         if (wcnt < IMG) mem[wcnt] = bus.buf_data;
         wcnt++;
         n_wr++;
      end
      bus.buf_full = (wcnt >= IMG);
      if (bus.infer_start === 1'b1) begin
         n_start++;
         start_cyc = cyc;
      end
      bus.infer_done = (infer_lat >= 0) && (cyc - start_cyc == infer_lat);
   end

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       wr_rdy;
      logic       exp_rdy;
      logic       exp_busy;
      logic       exp_clr;
      logic       exp_wr;
      logic [7:0] exp_bd;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 1);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_buf_clear"}, 32'(bus.buf_clear), 0);
      chk({tag, "_buf_wr"}, 32'(bus.buf_write_request), 0);
      chk({tag, "_infer_start"}, 32'(bus.infer_start), 0);
      chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
      chk({tag, "_buf_data"}, 32'(bus.buf_data), 0);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int drop_pct, output int acc);
      acc = -1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      for (int t = 0; t < 200; t++) begin
         bus.buf_write_ready = ($urandom_range(99) >= drop_pct);
         #1;
         if (bus.rx_ready) begin
            acc = cyc;
            tick();
            bus.rx_valid        = 1'b0;
            bus.buf_write_ready = 1'b1;
            return;
         end
         tick();
      end
      checks++;
      errors++;
      $display("FAIL rx_accept: byte %0h not accepted within 200 cycles", b);
      bus.rx_valid        = 1'b0;
      bus.buf_write_ready = 1'b1;
   endtask

   task automatic wait_tx(output int rise, output logic [7:0] data);
      rise = -1;
      data = 8'h00;
      for (int t = 0; t < 2000; t++) begin
         if (bus.tx_valid === 1'b1) begin
            rise = cyc;
            data = bus.tx_data;
            return;
         end
         tick();
      end
      checks++;
      errors++;
      $display("FAIL tx_valid_wait: no tx_valid within 2000 cycles");
   endtask

   task automatic handshake(input int stall, input logic [7:0] d);
      for (int k = 0; k < stall; k++) begin
         tick();
         chk("tx_valid_held", 32'(bus.tx_valid), 1);
         chk("tx_data_held", 32'(bus.tx_data), 32'(d));
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      chk("post_tx_valid", 32'(bus.tx_valid), 0);
      chk("post_tx_busy", 32'(bus.busy), 0);
      chk("post_tx_rx_ready", 32'(bus.rx_ready), 1);
   endtask

   // One frame: optional junk in IDLE, CMD_START, nbytes image bytes, then the result exchange.
   task automatic run_frame(input int nbytes, input int drop_pct, input int drop_at,
                            input int lat, input logic [3:0] cls, input int stall);
      logic [7:0] img [IMG];
      logic [7:0] d, exp_d;
      int w0, s0, c0, acc, rise, exp_rise, bad, junk;
      bus.infer_result = cls;
      infer_lat = lat;
      w0 = n_wr; s0 = n_start; c0 = n_clear;
      junk = $urandom_range(2);
      for (int g = 0; g < junk; g++) send_byte(8'($urandom_range(8'hA4)), 0, acc);
      send_byte(8'hA5, 0, acc);
      chk("start_busy", 32'(bus.busy), 1);
      chk("start_clear", 32'(bus.buf_clear), 1);
      for (int i = 0; i < nbytes; i++) begin
         img[i] = 8'($urandom_range(255));
         if (i == drop_at) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = img[i];
            bus.buf_write_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               #1 chk("drop_rx_ready", 32'(bus.rx_ready), 0);
               tick();
            end
         end else if ($urandom_range(7) == 0) begin
            tick();
         end
         send_byte(img[i], drop_pct, acc);
      end
      wait_tx(rise, d);
      if (nbytes < IMG) begin
         exp_d = 8'hFE;
         exp_rise = acc + RXT + 2;
         chk("rx_to_no_start", 32'(n_start - s0), 0);
      end else begin
         chk("infer_start_count", 32'(n_start - s0), 1);
         if (lat >= 0 && lat < INT) begin
            exp_d = {4'h0, cls};
            exp_rise = start_cyc + lat + 1;
         end else begin
            exp_d = 8'hFF;
            exp_rise = start_cyc + INT;
         end
      end
      chk("tx_data", 32'(d), 32'(exp_d));
      chk("tx_rise_cycle", 32'(rise), 32'(exp_rise));
      chk("write_count", 32'(n_wr - w0), 32'(nbytes));
      chk("clear_count", 32'(n_clear - c0), 1);
      bad = 0;
      for (int i = 0; i < nbytes; i++) if (mem[i] !== img[i]) bad++;
      chk("image_bytes", 32'(bad), 0);
      handshake(stall, exp_d);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      int nb, lat;
      tbl[0] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[4] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[5] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
      tbl[6] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C};
      tbl[7] = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};

      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      bus.buf_write_ready = 1'b1;
      bus.tx_ready = 1'b0;
      bus.infer_result = 4'h0;
      tick();
      tick();
      check_reset("reset");
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         bus.rx_valid = tbl[i].v;
         bus.rx_data = tbl[i].d;
         bus.buf_write_ready = tbl[i].wr_rdy;
         #1 chk($sformatf("vec%0d_rx_ready", i), 32'(bus.rx_ready), 32'(tbl[i].exp_rdy));
         tick();
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].exp_busy));
         chk($sformatf("vec%0d_clear", i), 32'(bus.buf_clear), 32'(tbl[i].exp_clr));
         chk($sformatf("vec%0d_wr", i), 32'(bus.buf_write_request), 32'(tbl[i].exp_wr));
         chk($sformatf("vec%0d_buf_data", i), 32'(bus.buf_data), 32'(tbl[i].exp_bd));
      end
      bus.rx_valid = 1'b0;
      bus.buf_write_ready = 1'b1;
      rst = 1'b1;
      tick();
      check_reset("abandon");
      rst = 1'b0;

      run_frame(IMG, 0, -1, 20, 4'd7, 3);
      run_frame(IMG, 0, 57, 20, 4'd2, 0);
      run_frame(40, 0, -1, 20, 4'd1, 2);
      run_frame(IMG, 0, -1, -1, 4'd5, 1);
      run_frame(IMG, 0, -1, INT - 1, 4'd9, 0);
      run_frame(IMG, 0, -1, INT, 4'd4, 0);

      send_byte(8'hA5, 0, acc);
      for (int i = 0; i < 60; i++) send_byte(8'($urandom_range(255)), 0, acc);
      rst = 1'b1;
      tick();
      check_reset("midframe");
      rst = 1'b0;
      run_frame(IMG, 10, -1, 15, 4'd3, 2);

      for (int r = 0; r < 8; r++) begin
         nb = ($urandom_range(5) == 0) ? int'($urandom_range(IMG - 1, 1)) : IMG;
         lat = ($urandom_range(4) == 0) ? -1 : int'($urandom_range(INT + 5, 1));
         run_frame(nb, int'($urandom_range(30)), -1, lat, 4'($urandom_range(9)),
                   int'($urandom_range(4)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
